// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one registered adder
// among NUM_REQ requesters; results leave on a valid/ready channel.
// Ports: clk, rst_n (async low); req, req_a, req_b (packed lanes);
// gnt (one-hot pulse); res_valid/res_ready, res_id, res_sum,
// res_overflow; busy (state != IDLE).
// Macro ADDER_SHARE_ARB_FIXED_PRIO_EN: fixed priority, lowest wins.
module adder_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [ID_W-1:0]          res_id,
   output logic [WIDTH:0]           res_sum,
   output logic                     res_overflow,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [ID_W-1:0]  op_id;
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  sel;
   logic             found;
   logic             grant;
   logic             load_res;
   logic             drop_res;
   logic [WIDTH:0]   sum;
   logic             ovf;

`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
   always_comb begin
      win   = '0;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel = ID_W'(i);
         if (!found && req[sel]) begin
            found = 1'b1;
            win   = sel;
         end
      end
   end
`else
   logic [ID_W-1:0] rr_ptr;
   int              idx;

   // Scan upward from rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      win   = '0;
      sel   = '0;
      idx   = 0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         sel = ID_W'(idx);
         if (!found && req[sel]) begin
            found = 1'b1;
            win   = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant    = 1'b0;
      load_res = 1'b0;
      drop_res = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            load_res = 1'b1;
            state_n  = RESP;
         end
         RESP: begin
            if (res_ready) begin
               drop_res = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Carry lands in bit WIDTH; overflow only looks at sign bits.
   assign sum = {1'b0, op_a} + {1'b0, op_b};
   assign ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                (sum[WIDTH-1] != op_a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt          <= '0;
         op_a         <= '0;
         op_b         <= '0;
         op_id        <= '0;
         res_valid    <= 1'b0;
         res_id       <= '0;
         res_sum      <= '0;
         res_overflow <= 1'b0;
      end else begin
         gnt <= grant ? (NUM_REQ'(1) << win) : '0;
         if (grant) begin
            op_a  <= req_a[win*WIDTH +: WIDTH];
            op_b  <= req_b[win*WIDTH +: WIDTH];
            op_id <= win;
         end
         if (load_res) begin
            res_sum      <= sum;
            res_overflow <= ovf;
            res_id       <= op_id;
            res_valid    <= 1'b1;
         end else if (drop_res) begin
            res_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized and directed bench for adder_share_arb
// against a transaction-level reference model.
module tb_adder_share_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  gnt;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [1:0]  res_id;
   logic [4:0]  res_sum;
   logic        res_overflow;
   logic        busy;

   logic [3:0]  a [4];
   logic [3:0]  b [4];

   int nchecks = 0;
   int nerrs = 0;
   int ptr = 0;
   int cycle = 0;
   int last_gnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   always_comb begin
      req_a = {a[3], a[2], a[1], a[0]};
      req_b = {b[3], b[2], b[1], b[0]};
   end

   adder_share_arb #(
      .NUM_REQ(4),
      .WIDTH(4),
      .ID_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .req_a(req_a),
      .req_b(req_b),
      .gnt(gnt),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_id(res_id),
      .res_sum(res_sum),
      .res_overflow(res_overflow),
      .busy(busy)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r);
      for (int k = 0; k < 4; k++)
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      return 0;
   endfunction

   function automatic void advance(input int w);
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
      ptr = 0;
`else
      ptr = (w + 1) % 4;
`endif
   endfunction

   function automatic logic [4:0] exp_sum(input logic [3:0] x,
                                          input logic [3:0] y);
      return 5'(int'(x) + int'(y));
   endfunction

   function automatic logic exp_ovf(input logic [3:0] x,
                                    input logic [3:0] y);
      int sx;
      int sy;
      sx = (x > 7) ? int'(x) - 16 : int'(x);
      sy = (y > 7) ? int'(y) - 16 : int'(y);
      return (sx + sy > 7) || (sx + sy < -8);
   endfunction

   task automatic check_zero(input string t);
      check({t, "_gnt"}, 32'(gnt), 0);
      check({t, "_valid"}, 32'(res_valid), 0);
      check({t, "_id"}, 32'(res_id), 0);
      check({t, "_sum"}, 32'(res_sum), 0);
      check({t, "_ovf"}, 32'(res_overflow), 0);
      check({t, "_busy"}, 32'(busy), 0);
   endtask

   task automatic run_txn(input logic [3:0] r, input int stall,
                          input logic [3:0] pend, input bit sp);
      int cyc;
      int w;
      logic [4:0] es;
      logic eo;
      req = r;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (gnt == 0 && cyc < 8);
      check("gnt_lat", cyc, 1);
      w = pick(r);
      check("gnt", 32'(gnt), 32'(1 << w));
      check("busy_exec", 32'(busy), 1);
      if (sp) check("gnt_space", cycle - last_gnt, 3);
      last_gnt = cycle;
      advance(w);
      es = exp_sum(a[w], b[w]);
      eo = exp_ovf(a[w], b[w]);
      req = pend;
      @(posedge clk); #1;
      check("valid", 32'(res_valid), 1);
      check("gnt_off", 32'(gnt), 0);
      check("id", 32'(res_id), w);
      check("sum", 32'(res_sum), 32'(es));
      check("ovf", 32'(res_overflow), 32'(eo));
      res_ready = (stall == 0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(res_valid), 1);
         check("hold_sum", 32'(res_sum), 32'(es));
         check("hold_id", 32'(res_id), w);
         check("hold_gnt", 32'(gnt), 0);
         if (i == stall - 1) res_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("valid_drop", 32'(res_valid), 0);
      check("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         a[i] = '0;
         b[i] = '0;
      end
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ptr = 0;

      for (int i = 0; i < 4; i++) begin
         a[i] = 4'(i + 1);
         b[i] = 4'(2 * i + 3);
      end
      for (int n = 0; n < 5; n++)
         run_txn(4'b1111, 0, (n < 4) ? 4'b1111 : 4'b0000, n > 0);

      a[0] = 4'b1111;
      b[0] = 4'b1111;
      run_txn(4'b0001, 0, 4'b0000, 1'b0);
      check("tp_single", 32'(exp_sum(a[0], b[0])), 32'h1e);

      a[1] = 4'b0101; b[1] = 4'b0101;
      a[2] = 4'b1001; b[2] = 4'b1001;
      a[3] = 4'b1100; b[3] = 4'b1100;
      a[0] = 4'b0011; b[0] = 4'b0011;
      run_txn(4'b0010, 0, 4'b0000, 1'b0);
      run_txn(4'b0100, 0, 4'b0000, 1'b0);
      run_txn(4'b1000, 0, 4'b0000, 1'b0);
      run_txn(4'b0001, 0, 4'b0000, 1'b0);

      run_txn(4'b0001, 5, 4'b0010, 1'b0);
      run_txn(4'b0010, 0, 4'b0000, 1'b0);

      run_txn(4'b1000, 0, 4'b0100, 1'b0);
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("wd_gnt", 32'(gnt), 0);
         check("wd_busy", 32'(busy), 0);
      end

      req = 4'b0010;
      @(posedge clk); #1;
      check("pre_rst_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      #2 rst_n = 1'b0;
      #1 check_zero("rst_exec");
      @(posedge clk); #1;
      rst_n = 1'b1;
      ptr = 0;
      run_txn(4'b1111, 0, 4'b0000, 1'b0);
      run_txn(4'b1000, 0, 4'b0000, 1'b0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            a[i] = 4'($urandom_range(0, 15));
            b[i] = 4'($urandom_range(0, 15));
         end
         run_txn(4'($urandom_range(1, 15)),
                 int'($urandom_range(0, 3)), 4'b0000, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerrs);
      $finish;
   end

endmodule
